// File: rtl/lsio_arb_pkg.sv
// Shared types and strobe encodings for the two-master LSIO arbiter.
package lsio_arb_pkg;

   typedef enum logic {
      MST_M0 = 1'b0,
      MST_M1 = 1'b1
   } master_id_t;

   typedef enum logic {
      LK_UNLOCKED = 1'b0,
      LK_LOCKED   = 1'b1
   } lock_state_t;

   localparam logic [3:0] STRB_READ  = 4'h0;
   localparam logic [3:0] STRB_WRITE = 4'hf;

   // Only full-word writes and plain reads reach the LSIO port.
   function automatic logic strb_legal(input logic [3:0] strb);
      return (strb == STRB_READ) || (strb == STRB_WRITE);
   endfunction

endpackage

// File: rtl/lsio_arb_lock.sv
// Bounded ownership lock: tracks the owner and breaks the lock if the other
// master is starved for LOCK_TIMEOUT-1 cycles.
module lsio_arb_lock
   import lsio_arb_pkg::*;
#(
   parameter int LOCK_TIMEOUT = 64
)
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       gnt_valid_i,
   input  logic       gnt_id_i,
   input  logic [1:0] lock_i,
   input  logic [1:0] req_i,
   output logic       lock_active_o,
   output logic       lock_owner_o,
   output logic       lock_break_o
);

   localparam int CW = $clog2(LOCK_TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_TIMEOUT - 1);

   lock_state_t   state_r;
   master_id_t    owner_r;
   logic [CW-1:0] cnt_r;
   logic          break_r;

   logic          owner_req_s;
   logic          owner_lock_s;
   logic          other_req_s;
   logic          release_s;
   logic          timeout_s;
   logic [CW-1:0] cnt_inc_s;

   // Owner/other views of the request lines and the release/timeout decision.
   always_comb begin
      owner_req_s  = (owner_r == MST_M1) ? req_i[1]  : req_i[0];
      owner_lock_s = (owner_r == MST_M1) ? lock_i[1] : lock_i[0];
      other_req_s  = (owner_r == MST_M1) ? req_i[0]  : req_i[1];
      release_s    = !owner_lock_s &&
                     (!owner_req_s || (gnt_valid_i && (gnt_id_i == owner_r)));
      if (cnt_r == CNT_MAX) begin
         cnt_inc_s = cnt_r;
      end else begin
         cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
      timeout_s = other_req_s && (cnt_inc_s == CNT_MAX);
   end

   // Lock FSM and starvation counter; release wins over a coincident timeout.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= LK_UNLOCKED;
         owner_r <= MST_M0;
         cnt_r   <= '0;
         break_r <= 1'b0;
      end else begin
         break_r <= 1'b0;
         case (state_r)
            LK_UNLOCKED: begin
               if (gnt_valid_i && lock_i[gnt_id_i]) begin
                  state_r <= LK_LOCKED;
                  owner_r <= master_id_t'(gnt_id_i);
                  cnt_r   <= '0;
               end else begin
                  cnt_r   <= '0;
               end
            end
            LK_LOCKED: begin
               if (release_s) begin
                  state_r <= LK_UNLOCKED;
                  cnt_r   <= '0;
               end else if (timeout_s) begin
                  state_r <= LK_UNLOCKED;
                  cnt_r   <= '0;
                  break_r <= 1'b1;
               end else if (other_req_s) begin
                  cnt_r   <= cnt_inc_s;
               end else begin
                  cnt_r   <= cnt_r;
               end
            end
            default: begin
               state_r <= LK_UNLOCKED;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   assign lock_active_o = (state_r == LK_LOCKED);
   assign lock_owner_o  = owner_r;
   assign lock_break_o  = break_r;

endmodule

// File: rtl/lsio_arbiter.sv
// Round-robin arbiter sharing the LSIO register port between the CPU data
// port (M0) and the debug/boot loader (M1), with bounded locking.
module lsio_arbiter
   import lsio_arb_pkg::*;
#(
   parameter int LOCK_TIMEOUT = 64,
   parameter int M0_PRIORITY  = 1
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   input  logic        m0_lock_i,
   input  logic [3:0]  m0_wstrb_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_gnt_o,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   input  logic        m1_lock_i,
   input  logic [3:0]  m1_wstrb_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_gnt_o,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,
   output logic        lsio_enable_o,
   output logic [3:0]  lsio_wstrb_o,
   output logic [31:0] lsio_addr_o,
   output logic [31:0] lsio_addr_prev_o,
   output logic [31:0] lsio_wvalue_o,
   input  logic [31:0] lsio_rvalue_i,
   output logic        strobe_err_o,
   output logic        lock_break_o
);

   logic        lock_active_s;
   logic        lock_owner_s;
   logic        gnt0_s;
   logic        gnt1_s;
   logic        gnt_any_s;
   master_id_t  win_id_s;
   logic [3:0]  win_strb_s;
   logic [31:0] win_addr_s;
   logic [31:0] win_wdata_s;

   master_id_t  last_grant_r;
   logic [31:0] addr_prev_r;
   logic [31:0] wdata_hold_r;
   logic        resp_valid_q;
   master_id_t  resp_id_q;
   logic        resp_is_read_q;

   // Grant selection: lock owner only, otherwise round-robin on contention.
   always_comb begin
      if (rst_i) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (lock_active_s) begin
         gnt0_s = m0_req_i && (lock_owner_s == MST_M0);
         gnt1_s = m1_req_i && (lock_owner_s == MST_M1);
      end else if (m0_req_i && m1_req_i) begin
         gnt0_s = (last_grant_r == MST_M1);
         gnt1_s = (last_grant_r == MST_M0);
      end else begin
         gnt0_s = m0_req_i;
         gnt1_s = m1_req_i;
      end
   end

   assign gnt_any_s   = gnt0_s || gnt1_s;
   assign win_id_s    = gnt1_s ? MST_M1     : MST_M0;
   assign win_strb_s  = gnt1_s ? m1_wstrb_i : m0_wstrb_i;
   assign win_addr_s  = gnt1_s ? m1_addr_i  : m0_addr_i;
   assign win_wdata_s = gnt1_s ? m1_wdata_i : m0_wdata_i;

   assign m0_gnt_o = gnt0_s;
   assign m1_gnt_o = gnt1_s;

   // Partial strobes are acknowledged but never reach the LSIO port.
   assign lsio_enable_o    = gnt_any_s && strb_legal(win_strb_s);
   assign strobe_err_o     = gnt_any_s && !strb_legal(win_strb_s);
   assign lsio_wstrb_o     = gnt_any_s ? win_strb_s  : STRB_READ;
   assign lsio_addr_o      = gnt_any_s ? win_addr_s  : addr_prev_r;
   assign lsio_wvalue_o    = gnt_any_s ? win_wdata_s : wdata_hold_r;
   assign lsio_addr_prev_o = addr_prev_r;

   // Round-robin history, held address/data and the one-deep response stage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_grant_r   <= (M0_PRIORITY != 0) ? MST_M1 : MST_M0;
         addr_prev_r    <= 32'h0000_0000;
         wdata_hold_r   <= 32'h0000_0000;
         resp_valid_q   <= 1'b0;
         resp_id_q      <= MST_M0;
         resp_is_read_q <= 1'b0;
      end else begin
         resp_valid_q <= gnt_any_s;
         if (gnt_any_s) begin
            last_grant_r   <= win_id_s;
            addr_prev_r    <= win_addr_s;
            wdata_hold_r   <= win_wdata_s;
            resp_id_q      <= win_id_s;
            resp_is_read_q <= (win_strb_s == STRB_READ);
         end else begin
            last_grant_r   <= last_grant_r;
            addr_prev_r    <= addr_prev_r;
            wdata_hold_r   <= wdata_hold_r;
            resp_id_q      <= resp_id_q;
            resp_is_read_q <= resp_is_read_q;
         end
      end
   end

   assign m0_rvalid_o = !rst_i && resp_valid_q && (resp_id_q == MST_M0);
   assign m1_rvalid_o = !rst_i && resp_valid_q && (resp_id_q == MST_M1);
   assign m0_rdata_o  = (m0_rvalid_o && resp_is_read_q) ? lsio_rvalue_i : 32'h0000_0000;
   assign m1_rdata_o  = (m1_rvalid_o && resp_is_read_q) ? lsio_rvalue_i : 32'h0000_0000;

   lsio_arb_lock #(
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
   ) u_lock (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .gnt_valid_i   (gnt_any_s),
      .gnt_id_i      (win_id_s),
      .lock_i        ({m1_lock_i, m0_lock_i}),
      .req_i         ({m1_req_i, m0_req_i}),
      .lock_active_o (lock_active_s),
      .lock_owner_o  (lock_owner_s),
      .lock_break_o  (lock_break_o)
   );

endmodule

// File: tb/tb_lsio_arbiter.sv
// Directed, table-driven bench for lsio_arbiter (LOCK_TIMEOUT=4, M0 first).
module tb_lsio_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        m0_req_i, m0_lock_i, m1_req_i, m1_lock_i;
   logic [3:0]  m0_wstrb_i, m1_wstrb_i;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        lsio_enable_o;
   logic [3:0]  lsio_wstrb_o;
   logic [31:0] lsio_addr_o, lsio_addr_prev_o, lsio_wvalue_o, lsio_rvalue_i;
   logic        strobe_err_o, lock_break_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   lsio_arbiter #(.LOCK_TIMEOUT(4), .M0_PRIORITY(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_lock_i(m0_lock_i), .m0_wstrb_i(m0_wstrb_i),
      .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o),
      .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_lock_i(m1_lock_i), .m1_wstrb_i(m1_wstrb_i),
      .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
      .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .lsio_enable_o(lsio_enable_o), .lsio_wstrb_o(lsio_wstrb_o),
      .lsio_addr_o(lsio_addr_o), .lsio_addr_prev_o(lsio_addr_prev_o),
      .lsio_wvalue_o(lsio_wvalue_o), .lsio_rvalue_i(lsio_rvalue_i),
      .strobe_err_o(strobe_err_o), .lock_break_o(lock_break_o)
   );

   typedef struct {
      logic        rst;
      logic        r0, l0;
      logic [3:0]  s0;
      logic [31:0] a0;
      logic        r1, l1;
      logic [3:0]  s1;
      logic [31:0] a1;
      logic [31:0] rv;
      logic        g0, g1, v0;
      logic [31:0] d0;
      logic        v1;
      logic [31:0] d1;
      logic        en;
      logic [3:0]  st;
      logic [31:0] ad, wv, pv;
      logic        se, lb;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst,
                      input logic r0, input logic l0, input logic [3:0] s0, input logic [31:0] a0,
                      input logic r1, input logic l1, input logic [3:0] s1, input logic [31:0] a1,
                      input logic [31:0] rv,
                      input logic g0, input logic g1, input logic v0, input logic [31:0] d0,
                      input logic v1, input logic [31:0] d1, input logic en, input logic [3:0] st,
                      input logic [31:0] ad, input logic [31:0] wv, input logic [31:0] pv,
                      input logic se, input logic lb);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.l0 = l0; v.s0 = s0; v.a0 = a0;
      v.r1 = r1; v.l1 = l1; v.s1 = s1; v.a1 = a1; v.rv = rv;
      v.g0 = g0; v.g1 = g1; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
      v.en = en; v.st = st; v.ad = ad; v.wv = wv; v.pv = pv; v.se = se; v.lb = lb;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic r0, input logic l0, input logic [3:0] s0,
                        input logic [31:0] a0, input logic r1, input logic l1,
                        input logic [3:0] s1, input logic [31:0] a1, input logic [31:0] rv);
      rst_i = rst;
      m0_req_i = r0; m0_lock_i = l0; m0_wstrb_i = s0; m0_addr_i = a0;
      m0_wdata_i = 32'hD0D0_0000 | a0;
      m1_req_i = r1; m1_lock_i = l1; m1_wstrb_i = s1; m1_addr_i = a1;
      m1_wdata_i = 32'hD1D1_0000 | a1;
      lsio_rvalue_i = rv;
   endtask

   localparam logic [3:0]  R = 4'h0;
   localparam logic [3:0]  W = 4'hf;
   localparam logic [31:0] Z = 32'h0;

   initial begin
      bit seen_break;
      int refused;

      drive(1'b1, 1'b0, 1'b0, R, Z, 1'b0, 1'b0, R, Z, Z);
      repeat (2) @(posedge clk_i);
      #1;

      //  rst r0 l0 s0 a0        r1 l1 s1 a1        rvalue         g0 g1 v0 d0            v1 d1            en st ad       wv             pv       se lb
      add(1, 0, 0, R, Z,        0, 0, R, Z,        Z,             0, 0, 0, Z,            0, Z,            0, R, Z,       Z,             Z,       0, 0);
      add(0, 1, 0, R, 32'h08,   0, 0, R, Z,        Z,             1, 0, 0, Z,            0, Z,            1, R, 32'h08,  32'hD0D00008,  Z,       0, 0);
      add(0, 0, 0, R, Z,        0, 0, R, Z,        32'h1234,      0, 0, 1, 32'h1234,     0, Z,            0, R, 32'h08,  32'hD0D00008,  32'h08,  0, 0);
      add(1, 0, 0, R, Z,        0, 0, R, Z,        Z,             0, 0, 0, Z,            0, Z,            0, R, 32'h08,  32'hD0D00008,  32'h08,  0, 0);
      add(0, 1, 0, R, 32'h10,   1, 0, R, 32'h20,   Z,             1, 0, 0, Z,            0, Z,            1, R, 32'h10,  32'hD0D00010,  Z,       0, 0);
      add(0, 1, 0, R, 32'h10,   1, 0, R, 32'h20,   32'hAAAA0001,  0, 1, 1, 32'hAAAA0001, 0, Z,            1, R, 32'h20,  32'hD1D10020,  32'h10,  0, 0);
      add(0, 1, 0, R, 32'h10,   1, 0, R, 32'h20,   32'hBBBB0002,  1, 0, 0, Z,            1, 32'hBBBB0002, 1, R, 32'h10,  32'hD0D00010,  32'h20,  0, 0);
      add(0, 1, 0, R, 32'h10,   1, 0, R, 32'h20,   32'hCCCC0003,  0, 1, 1, 32'hCCCC0003, 0, Z,            1, R, 32'h20,  32'hD1D10020,  32'h10,  0, 0);
      add(0, 0, 0, R, Z,        0, 0, R, Z,        32'hDDDD0004,  0, 0, 0, Z,            1, 32'hDDDD0004, 0, R, 32'h20,  32'hD1D10020,  32'h20,  0, 0);
      add(0, 0, 0, R, Z,        1, 1, R, 32'h14,   Z,             0, 1, 0, Z,            0, Z,            1, R, 32'h14,  32'hD1D10014,  32'h20,  0, 0);
      add(0, 1, 0, R, 32'h30,   1, 1, W, 32'h14,   32'h5555,      0, 1, 0, Z,            1, 32'h5555,     1, W, 32'h14,  32'hD1D10014,  32'h14,  0, 0);
      add(0, 1, 0, R, 32'h30,   1, 0, R, 32'h14,   32'h6666,      0, 1, 0, Z,            1, Z,            1, R, 32'h14,  32'hD1D10014,  32'h14,  0, 0);
      add(0, 1, 0, R, 32'h30,   0, 0, R, Z,        32'h7777,      1, 0, 0, Z,            1, 32'h7777,     1, R, 32'h30,  32'hD0D00030,  32'h14,  0, 0);
      add(0, 1, 0, 4'h3, 32'h40, 0, 0, R, Z,       32'h8888,      1, 0, 1, 32'h8888,     0, Z,            0, 4'h3, 32'h40, 32'hD0D00040, 32'h30,  1, 0);
      add(0, 0, 0, R, Z,        0, 0, R, Z,        32'h9999,      0, 0, 1, Z,            0, Z,            0, R, 32'h40,  32'hD0D00040,  32'h40,  0, 0);
      add(0, 1, 1, R, 32'h50,   0, 0, R, Z,        Z,             1, 0, 0, Z,            0, Z,            1, R, 32'h50,  32'hD0D00050,  32'h40,  0, 0);
      add(1, 0, 1, R, Z,        1, 0, R, 32'h60,   32'hEEEE,      0, 0, 0, Z,            0, Z,            0, R, 32'h50,  32'hD0D00050,  32'h50,  0, 0);
      add(0, 0, 1, R, Z,        1, 0, R, 32'h60,   32'hEEEE,      0, 1, 0, Z,            0, Z,            1, R, 32'h60,  32'hD1D10060,  Z,       0, 0);
      add(0, 0, 0, R, Z,        0, 0, R, Z,        32'h1111,      0, 0, 0, Z,            1, 32'h1111,     0, R, 32'h60,  32'hD1D10060,  32'h60,  0, 0);

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].r0, vq[i].l0, vq[i].s0, vq[i].a0,
               vq[i].r1, vq[i].l1, vq[i].s1, vq[i].a1, vq[i].rv);
         #4;
         chk($sformatf("v%0d m0_gnt", i),    {31'h0, m0_gnt_o},      {31'h0, vq[i].g0});
         chk($sformatf("v%0d m1_gnt", i),    {31'h0, m1_gnt_o},      {31'h0, vq[i].g1});
         chk($sformatf("v%0d m0_rvalid", i), {31'h0, m0_rvalid_o},   {31'h0, vq[i].v0});
         chk($sformatf("v%0d m0_rdata", i),  m0_rdata_o,             vq[i].d0);
         chk($sformatf("v%0d m1_rvalid", i), {31'h0, m1_rvalid_o},   {31'h0, vq[i].v1});
         chk($sformatf("v%0d m1_rdata", i),  m1_rdata_o,             vq[i].d1);
         chk($sformatf("v%0d enable", i),    {31'h0, lsio_enable_o}, {31'h0, vq[i].en});
         chk($sformatf("v%0d wstrb", i),     {28'h0, lsio_wstrb_o},  {28'h0, vq[i].st});
         chk($sformatf("v%0d addr", i),      lsio_addr_o,            vq[i].ad);
         chk($sformatf("v%0d wvalue", i),    lsio_wvalue_o,          vq[i].wv);
         chk($sformatf("v%0d addr_prev", i), lsio_addr_prev_o,       vq[i].pv);
         chk($sformatf("v%0d strobe_err", i), {31'h0, strobe_err_o}, {31'h0, vq[i].se});
         chk($sformatf("v%0d lock_break", i), {31'h0, lock_break_o}, {31'h0, vq[i].lb});
         @(posedge clk_i);
         #1;
      end

      // Lock timeout: M1 locks and keeps lock asserted while M0 waits.
      drive(1'b0, 1'b0, 1'b0, R, Z, 1'b1, 1'b1, R, 32'h70, Z);
      #4;
      chk("to lock_grant", {31'h0, m1_gnt_o}, 32'h1);
      @(posedge clk_i);
      #1;
      seen_break = 1'b0;
      refused = 0;
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b1, 1'b0, R, 32'h80, 1'b1, 1'b1, R, 32'h70, Z);
         #4;
         if (lock_break_o) begin
            seen_break = 1'b1;
            break;
         end
         chk($sformatf("to refused%0d m0_gnt", k), {31'h0, m0_gnt_o}, 32'h0);
         chk($sformatf("to refused%0d m1_gnt", k), {31'h0, m1_gnt_o}, 32'h1);
         refused++;
         @(posedge clk_i);
         #1;
      end
      n_checks++;
      if (!seen_break) begin
         n_errors++;
         $display("FAIL to break_seen: got no lock_break_o within 8 cycles, expected a pulse");
      end else begin
         chk("to refused_cycles", refused, 32'd3);
         chk("to m0_gnt_after_break", {31'h0, m0_gnt_o}, 32'h1);
         chk("to m1_gnt_after_break", {31'h0, m1_gnt_o}, 32'h0);
      end
      @(posedge clk_i);
      #1;
      drive(1'b0, 1'b0, 1'b0, R, Z, 1'b0, 1'b0, R, Z, Z);
      #4;
      chk("to break_single_pulse", {31'h0, lock_break_o}, 32'h0);
      chk("to m0_rvalid_after_break", {31'h0, m0_rvalid_o}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
